fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding read, a single output slot, and redirect squashing.
// Optional feature macro: FETCH_STALL_CNT_EN adds the stall_cycles saturating counter port.
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instruction,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        free_s;
  logic        read_s;
  logic [15:0] target_s;

  assign free_s   = !valid_q || !stall;
  assign target_s = {redirect_pc[15:1], 1'b0};

  // Next-state, slot update and memory request generation.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    valid_d      = valid_q;
    read_s       = 1'b0;
    imem_address = pc_q;

    case (state_q)
      ST_FETCH: begin
        read_s       = free_s;
        imem_address = pc_q;
        req_addr_d   = pc_q;
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target_s;
          // Only a read still in flight needs its late response swallowed.
          if (read_s && !imem_resp) begin
            state_d = ST_DISCARD;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (read_s && imem_resp) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + 16'd2;
        end else if (valid_q && !stall) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      ST_DISCARD: begin
        read_s       = 1'b1;
        imem_address = req_addr_q;
        valid_d      = 1'b0;
        if (redirect) begin
          pc_d    = target_s;
          state_d = ST_DISCARD;
        end else if (imem_resp) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: begin
        state_d = ST_FETCH;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_read   = read_s && !reset;
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign valid       = valid_q;
  assign pc_plus2    = pc_out_q + 16'd2;

  // State and output slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= 16'h0000;
      req_addr_q <= 16'h0000;
      instr_q    <= 16'h0000;
      pc_out_q   <= 16'h0000;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles a live instruction was held by decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
    end else if (valid_q && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_read;
  logic [15:0] imem_address;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        valid;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .pc_plus2     (pc_plus2),
    .valid        (valid)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a response for the current request and check the captured slot.
  task automatic fetch_one(input logic [15:0] addr, input logic [15:0] data);
    stall      = 1'b0;
    redirect   = 1'b0;
    imem_resp  = 1'b1;
    imem_rdata = data;
    #1;
    chk("fetch_read", {15'd0, imem_read}, 16'd1);
    chk("fetch_addr", imem_address, addr);
    step();
    chk("fetch_valid", {15'd0, valid}, 16'd1);
    chk("fetch_pc_out", pc_out, addr);
    chk("fetch_pc_plus2", pc_plus2, addr + 16'd2);
    chk("fetch_instr", instruction, data);
  endtask

  initial begin
    reset       = 1'b1;
    imem_rdata  = 16'h0000;
    imem_resp   = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    // Reset state, while reset is still asserted.
    step();
    chk("rst_read", {15'd0, imem_read}, 16'd0);
    chk("rst_valid", {15'd0, valid}, 16'd0);
    chk("rst_pc_out", pc_out, 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
`ifdef FETCH_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cycles, 16'h0000);
`endif
    reset = 1'b0;
    #1;
    chk("first_read", {15'd0, imem_read}, 16'd1);
    chk("first_addr", imem_address, 16'h0000);

    // Back-to-back fetches with a constant instruction.
    for (int i = 0; i < 3; i++) fetch_one(16'(2 * i), 16'h1234);
    for (int a = 6; a <= 16; a += 2) fetch_one(16'(a), 16'hA000 | 16'(a));

    // Stall with pc_out=0x0010 for three cycles; a response must be ignored.
    stall      = 1'b1;
    imem_resp  = 1'b1;
    imem_rdata = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_read", {15'd0, imem_read}, 16'd0);
      step();
      chk("stall_valid", {15'd0, valid}, 16'd1);
      chk("stall_pc_out", pc_out, 16'h0010);
      chk("stall_instr", instruction, 16'hA010);
    end
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cycles, 16'd3);
`endif
    fetch_one(16'h0012, 16'h7012);
    for (int a = 20; a <= 30; a += 2) fetch_one(16'(a), 16'h7000 | 16'(a));

    // Redirect while the read of 0x0020 is outstanding.
    imem_resp   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0301;
    #1;
    chk("rd_pre_addr", imem_address, 16'h0020);
    chk("rd_pre_read", {15'd0, imem_read}, 16'd1);
    step();
    chk("rd_valid", {15'd0, valid}, 16'd0);
    redirect = 1'b0;
    stall    = 1'b1;
    #1;
    chk("disc_read_stall", {15'd0, imem_read}, 16'd1);
    chk("disc_addr", imem_address, 16'h0020);
    step();
    chk("disc_addr_hold", imem_address, 16'h0020);
    stall      = 1'b0;
    imem_resp  = 1'b1;
    imem_rdata = 16'hDEAD;
    step();
    chk("disc_drop_valid", {15'd0, valid}, 16'd0);
    imem_resp = 1'b0;
    #1;
    chk("post_disc_addr", imem_address, 16'h0300);
    fetch_one(16'h0300, 16'h3300);

    // Redirect and response together while the slot is stalled.
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0400;
    imem_resp   = 1'b1;
    imem_rdata  = 16'hCAFE;
    step();
    chk("rs_valid", {15'd0, valid}, 16'd0);
    redirect  = 1'b0;
    imem_resp = 1'b0;
    #1;
    chk("rs_read", {15'd0, imem_read}, 16'd1);
    chk("rs_addr", imem_address, 16'h0400);

    // Wrap at the top of the address space.
    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    imem_resp   = 1'b1;
    step();
    chk("wrap_redir_valid", {15'd0, valid}, 16'd0);
    fetch_one(16'hFFFE, 16'h5555);
    #1;
    chk("wrap_next_addr", imem_address, 16'h0000);
    fetch_one(16'h0000, 16'h6666);

    // Enter DISCARD with 0x0002 outstanding, then reset over a late response.
    imem_resp   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0800;
    step();
    redirect = 1'b0;
    #1;
    chk("pre_rst_disc_addr", imem_address, 16'h0002);
    reset       = 1'b1;
    imem_resp   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 16'h0900;
    #1;
    chk("rst_cycle_read", {15'd0, imem_read}, 16'd0);
    step();
    chk("rst2_valid", {15'd0, valid}, 16'd0);
    reset     = 1'b0;
    redirect  = 1'b0;
    imem_resp = 1'b0;
    #1;
    chk("rst2_read", {15'd0, imem_read}, 16'd1);
    chk("rst2_addr", imem_address, 16'h0000);
`ifdef FETCH_STALL_CNT_EN
    chk("rst2_stall_cnt", stall_cycles, 16'h0000);
`endif
    fetch_one(16'h0000, 16'h4321);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
